programmable_clk_divider: RTL and testbench
===========================================

// Module: programmable_clk_divider
//
// PURPOSE
//  Next-generation low-frequency clock source. Divides clk_high by a divisor that
//  software can change at run time, with glitch-free updates that take effect only
//  on a period boundary. Provides a toggling clock (clk_low) and a one-cycle
//  clock-enable pulse (tick). Sits between the board oscillator and the LED-cube
//  scan/animation logic, which runs on tick or clk_low.
//
// PARAMETERS
//  DIV_WIDTH    20        width of the counter and the divisor (bits)
//  DEFAULT_DIV  20'hFFFFF divisor loaded at reset: terminal count, so period = DIV+1
//
// PORTS
//  clk_high    in   1          system clock; all logic is on its rising edge
//  reset       in   1          synchronous, active-high; has priority over everything
//  enable      in   1          1 = count; 0 = hold (freeze counter and clk_low)
//  sync_clear  in   1          phase restart: counter <= 0, clk_low <= 1, no tick
//  div_value   in   DIV_WIDTH  new terminal count; sampled when div_load = 1
//  div_load    in   1          one-cycle request to load div_value
//  div_ack     out  1          one-cycle pulse when the pending divisor becomes active
//  tick        out  1          one-cycle pulse on every terminal count
//  clk_low     out  1          divided clock; toggles on every terminal count
//  div_active  out  DIV_WIDTH  divisor currently in use
//
// BEHAVIOUR
//  - Reset: counter = 0, clk_low = 1, tick = 0, div_ack = 0, div_active = DEFAULT_DIV,
//    pending = 0. All outputs are registered.
//  - FSM has 2 states, set by enable each cycle. Reset value is RUN.
//    RUN: counter increments by 1. When counter == div_active, the counter goes to 0,
//    and on the same edge clk_low toggles and tick = 1 for the next cycle.
//    HOLD: counter and clk_low hold their values, tick = 0.
//  - Rates: tick period = div_active+1 cycles; clk_low period = 2*(div_active+1)
//    cycles at 50% duty. A divisor of 0 is legal: tick stays high, and clk_low
//    toggles every cycle.
//  - Load handshake: div_load = 1 copies div_value into pending_div and sets pending.
//    A load while pending is already set overwrites pending_div, and only one
//    div_ack is produced.
//  - The pending value is applied, meaning div_active <= pending_div, pending <= 0,
//    and div_ack = 1 on the next cycle, at any of these points:
//    (a) a terminal count in RUN, on the same edge as the counter wrap;
//    (b) any cycle in HOLD;
//    (c) a sync_clear.
//  - A load in the same cycle as an apply point stores the value only. It is applied
//    at the next apply point, never in the same edge.
//  - sync_clear has priority over a terminal count in the same cycle: no toggle and
//    no tick. It works in both RUN and HOLD.
//  - If the counter is already > div_active (this cannot happen through the apply
//    rules, but guard for it), treat it as a terminal count.
//  - Counter arithmetic wraps modulo 2^DIV_WIDTH. It never exceeds div_active in
//    normal operation.
//  - Reset mid-operation discards the pending value, and no div_ack is produced.
//
// TESTING (bench: DIV_WIDTH=4, DEFAULT_DIV=3)
//  1. Release reset with enable=1 -> clk_low=1 at reset; tick high 1 cycle every
//     4 clocks; clk_low period 8 clocks.
//  2. Load div_value=1 mid-period at counter=1 -> div_active stays 3 until the wrap;
//     div_ack 1 cycle after the wrap; then tick every 2 clocks.
//  3. Hold enable=0 for 5 cycles at counter=2 -> counter, clk_low and tick=0 frozen;
//     resume -> first tick after 2 more clocks.
//  4. Load 5, then 7 in the next cycle, before a wrap -> a single div_ack;
//     div_active=7; tick period 8.
//  5. Assert sync_clear in the same cycle as a terminal count -> no tick; clk_low=1;
//     counter=0; next tick 4 clocks later.
//  6. Load div_value=0, then wait for it to apply -> tick stays 1 and clk_low toggles
//     every clock. Assert reset with a load pending -> div_active=3, no div_ack.

Source files
------------

// File: rtl/programmable_clk_divider.sv
// Run-time programmable divider: emits a one-cycle tick and a 50% duty clk_low,
// with divisor changes deferred to a period boundary, a hold cycle or a phase restart.
module programmable_clk_divider #(
    parameter int                   DIV_WIDTH   = 20,
    parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 20'hFFFFF
) (
    input  logic                 clk_high,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sync_clear,
    input  logic [DIV_WIDTH-1:0] div_value,
    input  logic                 div_load,
    output logic                 div_ack,
    output logic                 tick,
    output logic                 clk_low,
    output logic [DIV_WIDTH-1:0] div_active
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]           state;
    logic [DIV_WIDTH-1:0] counter;
    logic [DIV_WIDTH-1:0] pending_div;
    logic                 pending;
    logic                 terminal;
    logic                 apply_point;
    logic                 apply;

    // The mode follows enable in the same cycle, so a hold freezes the very next edge.
    always_comb begin
        state       = enable ? ST_RUN : ST_HOLD;
        terminal    = (counter >= div_active);
        apply_point = sync_clear || (state == ST_HOLD) || terminal;
        apply       = apply_point && pending;
    end

    always_ff @(posedge clk_high) begin
        if (reset) begin
            counter <= '0;
            clk_low <= 1'b1;
            tick    <= 1'b0;
        end else if (sync_clear) begin
            counter <= '0;
            clk_low <= 1'b1;
            tick    <= 1'b0;
        end else if (state == ST_RUN) begin
            if (terminal) begin
                counter <= '0;
                clk_low <= ~clk_low;
                tick    <= 1'b1;
            end else begin
                counter <= counter + DIV_WIDTH'(1);
                tick    <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    // A load on an apply edge only refills pending; the old pending value still applies.
    always_ff @(posedge clk_high) begin
        if (reset) begin
            div_active  <= DEFAULT_DIV;
            pending_div <= DEFAULT_DIV;
            pending     <= 1'b0;
            div_ack     <= 1'b0;
        end else begin
            div_ack <= apply;
            if (apply) begin
                div_active <= pending_div;
            end
            if (div_load) begin
                pending_div <= div_value;
                pending     <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_programmable_clk_divider.sv
// Directed bench for programmable_clk_divider with DIV_WIDTH=4, DEFAULT_DIV=3.
module tb_programmable_clk_divider;

    localparam int W = 4;

    logic         clk_high = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b1;
    logic         sync_clear = 1'b0;
    logic [W-1:0] div_value = '0;
    logic         div_load = 1'b0;
    logic         div_ack;
    logic         tick;
    logic         clk_low;
    logic [W-1:0] div_active;

    int checks   = 0;
    int failures = 0;

    programmable_clk_divider #(
        .DIV_WIDTH  (W),
        .DEFAULT_DIV(4'd3)
    ) dut (
        .clk_high  (clk_high),
        .reset     (reset),
        .enable    (enable),
        .sync_clear(sync_clear),
        .div_value (div_value),
        .div_load  (div_load),
        .div_ack   (div_ack),
        .tick      (tick),
        .clk_low   (clk_low),
        .div_active(div_active)
    );

    always #5 clk_high = ~clk_high;

    typedef struct {
        logic         r;
        logic         en;
        logic         sc;
        logic         ld;
        logic [W-1:0] dv;
        logic         t;
        logic         c;
        logic         a;
        logic [W-1:0] act;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(logic r, logic en, logic sc, logic ld, logic [W-1:0] dv,
                                logic t, logic c, logic a, logic [W-1:0] act);
        vec_t v;
        v.r = r; v.en = en; v.sc = sc; v.ld = ld; v.dv = dv;
        v.t = t; v.c = c; v.a = a; v.act = act;
        return v;
    endfunction

    task automatic check_val(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, then sample just after it.
    task automatic step(input logic r, input logic en, input logic sc, input logic ld,
                        input logic [W-1:0] dv);
        reset = r; enable = en; sync_clear = sc; div_load = ld; div_value = dv;
        @(posedge clk_high);
        #1;
    endtask

    task automatic expect_out(string tag, logic t, logic c, logic a, logic [W-1:0] act);
        check_val({tag, ".tick"}, int'(tick), int'(t));
        check_val({tag, ".clk_low"}, int'(clk_low), int'(c));
        check_val({tag, ".div_ack"}, int'(div_ack), int'(a));
        check_val({tag, ".div_active"}, int'(div_active), int'(act));
    endtask

    task automatic do_reset(string tag);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        expect_out({tag, ".reset"}, 0, 1, 0, 3);
    endtask

    initial begin
        logic exp_clk;

        // Reset, free run at divisor 3, mid-period load of 1, sync_clear on a terminal count.
        vecs[0]  = mk(1, 1, 0, 0, 0, 0, 1, 0, 3);
        vecs[1]  = mk(1, 1, 0, 0, 0, 0, 1, 0, 3);
        vecs[2]  = mk(0, 1, 0, 0, 0, 0, 1, 0, 3);
        vecs[3]  = mk(0, 1, 0, 0, 0, 0, 1, 0, 3);
        vecs[4]  = mk(0, 1, 0, 0, 0, 0, 1, 0, 3);
        vecs[5]  = mk(0, 1, 0, 0, 0, 1, 0, 0, 3);
        vecs[6]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 3);
        vecs[7]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 3);
        vecs[8]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 3);
        vecs[9]  = mk(0, 1, 0, 0, 0, 1, 1, 0, 3);
        vecs[10] = mk(0, 1, 0, 0, 0, 0, 1, 0, 3);
        vecs[11] = mk(0, 1, 0, 1, 1, 0, 1, 0, 3);
        vecs[12] = mk(0, 1, 0, 0, 0, 0, 1, 0, 3);
        vecs[13] = mk(0, 1, 0, 0, 0, 1, 0, 1, 1);
        vecs[14] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1);
        vecs[15] = mk(0, 1, 0, 0, 0, 1, 1, 0, 1);
        vecs[16] = mk(0, 1, 0, 0, 0, 0, 1, 0, 1);
        vecs[17] = mk(0, 1, 0, 0, 0, 1, 0, 0, 1);
        vecs[18] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1);
        vecs[19] = mk(0, 1, 1, 0, 0, 0, 1, 0, 1);
        vecs[20] = mk(0, 1, 0, 0, 0, 0, 1, 0, 1);
        vecs[21] = mk(0, 1, 0, 0, 0, 1, 0, 0, 1);

        for (int i = 0; i < 22; i++) begin
            step(vecs[i].r, vecs[i].en, vecs[i].sc, vecs[i].ld, vecs[i].dv);
            expect_out($sformatf("vec%0d", i), vecs[i].t, vecs[i].c, vecs[i].a, vecs[i].act);
        end

        // Hold at counter=2 for 5 cycles, then resume: tick two clocks later.
        do_reset("hold");
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0);
            expect_out($sformatf("hold.frozen%0d", i), 0, 1, 0, 3);
        end
        step(0, 1, 0, 0, 0);
        expect_out("hold.resume1", 0, 1, 0, 3);
        step(0, 1, 0, 0, 0);
        expect_out("hold.resume2", 1, 0, 0, 3);

        // Back-to-back loads of 5 then 7: one ack, divisor 7, tick period 8.
        do_reset("reload");
        step(0, 1, 0, 1, 5);
        expect_out("reload.ld5", 0, 1, 0, 3);
        step(0, 1, 0, 1, 7);
        expect_out("reload.ld7", 0, 1, 0, 3);
        step(0, 1, 0, 0, 0);
        expect_out("reload.c3", 0, 1, 0, 3);
        step(0, 1, 0, 0, 0);
        expect_out("reload.apply", 1, 0, 1, 7);
        exp_clk = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 0, 0, 0);
            if (i % 8 == 0) exp_clk = ~exp_clk;
            expect_out($sformatf("reload.run%0d", i), (i % 8 == 0), exp_clk, 0, 7);
        end

        // sync_clear on the terminal count at divisor 3.
        do_reset("sclr");
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        expect_out("sclr.clear", 0, 1, 0, 3);
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 0, 0, 0);
            expect_out($sformatf("sclr.after%0d", i), (i == 4), (i != 4), 0, 3);
        end

        // Pending value applied by sync_clear.
        do_reset("sclr_apply");
        step(0, 1, 0, 1, 2);
        step(0, 1, 1, 0, 0);
        expect_out("sclr_apply.apply", 0, 1, 1, 2);
        step(0, 1, 0, 0, 0);
        expect_out("sclr_apply.next", 0, 1, 0, 2);

        // Load on a wrap edge is stored only; the next hold cycle applies it.
        do_reset("defer");
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 2);
        expect_out("defer.wrap", 1, 0, 0, 3);
        step(0, 0, 0, 0, 0);
        expect_out("defer.hold_apply", 0, 0, 1, 2);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        expect_out("defer.c2", 0, 0, 0, 2);
        step(0, 1, 0, 0, 0);
        expect_out("defer.wrap2", 1, 1, 0, 2);

        // Hold-apply shrinks the divisor below the counter: next RUN edge wraps at once.
        do_reset("guard");
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0);
        expect_out("guard.hold_apply", 0, 1, 1, 1);
        step(0, 1, 0, 0, 0);
        expect_out("guard.wrap", 1, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        expect_out("guard.c1", 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        expect_out("guard.wrap2", 1, 1, 0, 1);

        // Divisor 0: tick stays high, clk_low toggles every clock; reset drops a pending load.
        do_reset("div0");
        step(0, 1, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        expect_out("div0.apply", 1, 0, 1, 0);
        exp_clk = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step(0, 1, 0, 0, 0);
            exp_clk = ~exp_clk;
            expect_out($sformatf("div0.run%0d", i), 1, exp_clk, 0, 0);
        end
        step(0, 1, 0, 1, 5);
        exp_clk = ~exp_clk;
        expect_out("div0.ld_pending", 1, exp_clk, 0, 0);
        step(1, 1, 0, 0, 0);
        expect_out("div0.reset", 0, 1, 0, 3);
        for (int i = 1; i <= 6; i++) begin
            step(0, 1, 0, 0, 0);
            expect_out($sformatf("div0.post%0d", i), (i == 4), (i < 4), 0, 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
